// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM fill/verify controller.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_SETUP,
    S_W_STROBE,
    S_W_HOLD,
    S_R_ADDR,
    S_R_CHECK,
    S_DONE
  } state_t;

  // Bit positions inside the 2-bit mode field.
  localparam int MODE_WRITE  = 0;
  localparam int MODE_VERIFY = 1;

  // Pattern word for index k: (2*k + seed) truncated to 'width' bits.
  // A width of 32 wraps the mask to all ones, so it needs no special case.
  function automatic logic [31:0] pattern(input logic [31:0] index,
                                          input logic [31:0] seed,
                                          input int          width);
    logic [31:0] sum;
    sum = (index << 1) + seed;
    return sum & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/ram_bist_ctrl.sv
// Fill-and-verify controller for a single-port asynchronous-read RAM.
// A run writes a deterministic pattern over an address window (3 cycles per
// word so address/data never move on a write-strobe edge), then reads the
// window back (2 cycles per word) and counts mismatches.
//
//   state      | meaning
//   -----------+---------------------------------------------------
//   S_IDLE     | waiting for start; RAM deselected
//   S_W_SETUP  | address/data driven, write strobe low
//   S_W_STROBE | write strobe high
//   S_W_HOLD   | write strobe low, address/data still held
//   S_R_ADDR   | read address driven
//   S_R_CHECK  | read data compared at the end of this cycle
//   S_DONE     | one-cycle completion pulse, results published
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int ADDR_SIZE   = 10,
  parameter int WORD_SIZE   = 8,
  parameter int MEMORY_SIZE = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [ADDR_SIZE-1:0] base_addr,
  input  logic [ADDR_SIZE:0]   count,
  input  logic [WORD_SIZE-1:0] seed,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_SIZE:0]   err_count,
  output logic [ADDR_SIZE-1:0] first_err_addr,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  input  logic [WORD_SIZE-1:0] ram_rdata,
  output logic                 ram_wr,
  output logic                 ram_cs
);

  if (MEMORY_SIZE != (1 << ADDR_SIZE)) begin : g_size_check
    $error("MEMORY_SIZE must equal 2**ADDR_SIZE");
  end

  localparam logic [ADDR_SIZE:0] CNT_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE:0] CNT_MAX = {(ADDR_SIZE+1){1'b1}};

  state_t               state, state_n;
  logic                 verify_q, verify_n;
  logic [ADDR_SIZE-1:0] base_q, base_n;
  logic [ADDR_SIZE:0]   count_q, count_n;
  logic [WORD_SIZE-1:0] seed_q, seed_n;
  logic [ADDR_SIZE:0]   k, k_n, k_inc;
  logic [ADDR_SIZE:0]   err_n;
  logic [ADDR_SIZE-1:0] first_n;
  logic                 first_seen, first_seen_n;
  logic                 pass_n;
  logic                 last_word;
  logic [WORD_SIZE-1:0] exp_word;
  logic                 busy_n, done_n, cs_n, wr_n;
  logic [ADDR_SIZE-1:0] addr_n;
  logic [WORD_SIZE-1:0] wdata_n;

  assign k_inc     = k + CNT_ONE;
  assign last_word = (k_inc == count_q);
  assign exp_word  = WORD_SIZE'(pattern(32'(k), 32'(seed_q), WORD_SIZE));

  // Next-state, counters and registered-output values.
  always_comb begin
    state_n      = state;
    verify_n     = verify_q;
    base_n       = base_q;
    count_n      = count_q;
    seed_n       = seed_q;
    k_n          = k;
    err_n        = err_count;
    first_n      = first_err_addr;
    first_seen_n = first_seen;
    pass_n       = pass;

    case (state)
      S_IDLE: begin
        if (start) begin
          verify_n     = mode[MODE_VERIFY];
          base_n       = base_addr;
          count_n      = count;
          seed_n       = seed;
          k_n          = '0;
          err_n        = '0;
          first_n      = '0;
          first_seen_n = 1'b0;
          pass_n       = 1'b0;
          if (count == '0 || mode == 2'b00) state_n = S_DONE;
          else if (mode[MODE_WRITE])        state_n = S_W_SETUP;
          else                              state_n = S_R_ADDR;
        end
      end
      S_W_SETUP:  state_n = S_W_STROBE;
      S_W_STROBE: state_n = S_W_HOLD;
      S_W_HOLD: begin
        if (!last_word) begin
          k_n     = k_inc;
          state_n = S_W_SETUP;
        end else if (verify_q) begin
          k_n     = '0;
          state_n = S_R_ADDR;
        end else begin
          state_n = S_DONE;
        end
      end
      S_R_ADDR: state_n = S_R_CHECK;
      S_R_CHECK: begin
        if (ram_rdata != exp_word) begin
          if (err_count != CNT_MAX) err_n = err_count + CNT_ONE;
          if (!first_seen) begin
            first_seen_n = 1'b1;
            first_n      = ram_addr;
          end
        end
        if (last_word) begin
          state_n = S_DONE;
        end else begin
          k_n     = k_inc;
          state_n = S_R_ADDR;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (state_n == S_DONE) pass_n = (err_n == '0);

    // RAM-side and status outputs are registered copies of what the next
    // state requires, so ram_wr comes straight from a flop.
    busy_n  = (state_n != S_IDLE);
    done_n  = (state_n == S_DONE);
    cs_n    = (state_n != S_IDLE) && (state_n != S_DONE);
    wr_n    = (state_n == S_W_STROBE);
    addr_n  = base_n + k_n[ADDR_SIZE-1:0];
    wdata_n = WORD_SIZE'(pattern(32'(k_n), 32'(seed_n), WORD_SIZE));
  end

  // State, captured run parameters, counters and output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      verify_q       <= 1'b0;
      base_q         <= '0;
      count_q        <= '0;
      seed_q         <= '0;
      k              <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_seen     <= 1'b0;
      pass           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ram_cs         <= 1'b0;
      ram_wr         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
    end else begin
      state          <= state_n;
      verify_q       <= verify_n;
      base_q         <= base_n;
      count_q        <= count_n;
      seed_q         <= seed_n;
      k              <= k_n;
      err_count      <= err_n;
      first_err_addr <= first_n;
      first_seen     <= first_seen_n;
      pass           <= pass_n;
      busy           <= busy_n;
      done           <= done_n;
      ram_cs         <= cs_n;
      ram_wr         <= wr_n;
      ram_addr       <= addr_n;
      ram_wdata      <= wdata_n;
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: drives directed runs against a level-sensitive RAM
// model and checks every active cycle against an expected-activity queue
// built from the run description, plus hand-computed literal results.
module tb_ram_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [9:0]  base_addr;
  logic [10:0] count;
  logic [7:0]  seed;
  logic        busy, done, pass;
  logic [10:0] err_count;
  logic [9:0]  first_err_addr;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_wr, ram_cs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_bist_ctrl #(.ADDR_SIZE(10), .WORD_SIZE(8), .MEMORY_SIZE(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .count(count), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_wr(ram_wr), .ram_cs(ram_cs)
  );

  // ram1 behaviour: asynchronous read, level-sensitive write, plus a fault
  // injection port so only this process ever writes the array.
  logic [7:0] mem [0:1023];
  logic       inj_en;
  logic [9:0] inj_addr;
  logic [7:0] inj_data;

  always @(ram_wr, ram_cs, ram_addr, ram_wdata, inj_en, inj_addr, inj_data) begin
    if (ram_cs && ram_wr) mem[ram_addr] = ram_wdata;
    if (inj_en) mem[inj_addr] = inj_data;
  end
  assign ram_rdata = mem[ram_addr];

  logic [7:0] model_mem [0:1023];

  typedef struct {
    logic        cs, wr, busy, done;
    logic        chk_addr, chk_wdata, chk_res;
    logic [9:0]  addr;
    logic [7:0]  wdata;
    logic        pass;
    logic [10:0] err;
    logic [9:0]  first;
  } exp_t;

  exp_t exp_q[$];
  exp_t cmp_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Compare process: one expected entry per clock after the start edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        cmp_e = exp_q.pop_front();
        check("busy", 32'(busy), 32'(cmp_e.busy));
        check("done", 32'(done), 32'(cmp_e.done));
        check("ram_cs", 32'(ram_cs), 32'(cmp_e.cs));
        check("ram_wr", 32'(ram_wr), 32'(cmp_e.wr));
        if (cmp_e.chk_addr)  check("ram_addr", 32'(ram_addr), 32'(cmp_e.addr));
        if (cmp_e.chk_wdata) check("ram_wdata", 32'(ram_wdata), 32'(cmp_e.wdata));
        if (cmp_e.chk_res) begin
          check("pass", 32'(pass), 32'(cmp_e.pass));
          check("err_count", 32'(err_count), 32'(cmp_e.err));
          check("first_err_addr", 32'(first_err_addr), 32'(cmp_e.first));
        end
      end
    end
  end

  task automatic push(input logic cs, input logic wr, input logic bsy, input logic dn,
                      input logic ca, input logic [9:0] a, input logic cw, input logic [7:0] w);
    exp_t e;
    e = '{cs: cs, wr: wr, busy: bsy, done: dn, chk_addr: ca, chk_wdata: cw,
          chk_res: 1'b0, addr: a, wdata: w, pass: 1'b0, err: '0, first: '0};
    exp_q.push_back(e);
  endtask

  task automatic push_res(input logic bsy, input logic dn, input logic ps,
                          input logic [10:0] er, input logic [9:0] fa);
    exp_t e;
    e = '{cs: 1'b0, wr: 1'b0, busy: bsy, done: dn, chk_addr: 1'b0, chk_wdata: 1'b0,
          chk_res: 1'b1, addr: '0, wdata: '0, pass: ps, err: er, first: fa};
    exp_q.push_back(e);
  endtask

  // One complete run. poke > 0 raises start again that many edges after the
  // accepted start (with different inputs), which must be ignored.
  task automatic run(input logic [1:0] m, input logic [9:0] b, input logic [10:0] n,
                     input logic [7:0] s, input int exp_lat, input int poke);
    int         errs, cyc;
    logic [9:0] first_a;
    logic       found;
    logic [9:0] a;
    logic [7:0] p;
    @(negedge clk);
    mode = m; base_addr = b; count = n; seed = s; start = 1'b1;
    errs = 0; first_a = '0; found = 1'b0;
    if (n != 0 && m != 2'b00) begin
      if (m[0]) begin
        for (int k = 0; k < int'(n); k++) begin
          a = b + 10'(k);
          p = 8'(2 * k + int'(s));
          model_mem[a] = p;
          push(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, a, 1'b1, p);
          push(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, a, 1'b1, p);
          push(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, a, 1'b1, p);
        end
      end
      if (m[1]) begin
        for (int k = 0; k < int'(n); k++) begin
          a = b + 10'(k);
          p = 8'(2 * k + int'(s));
          push(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, a, 1'b0, 8'h00);
          push(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, a, 1'b0, 8'h00);
          if (model_mem[a] != p) begin
            if (errs < 2047) errs++;
            if (!found) begin found = 1'b1; first_a = a; end
          end
        end
      end
    end
    push_res(1'b1, 1'b1, errs == 0, 11'(errs), first_a);
    for (int i = 0; i < 3; i++) push_res(1'b0, 1'b0, errs == 0, 11'(errs), first_a);

    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      #1;
      start = (poke > 0 && cyc == poke);
      if (cyc == 1) begin
        mode = 2'b11; base_addr = 10'd777; count = 11'd5; seed = 8'd99;
      end
    end while (!done && cyc < 6000);
    start = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: no done after %0d cycles", cyc);
    end else begin
      check("latency", 32'(cyc - 1), 32'(exp_lat));
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      @(posedge clk);
      #2;
      cyc++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = '0; base_addr = '0; count = '0; seed = '0;
    inj_en = 1'b0; inj_addr = '0; inj_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_first", 32'(first_err_addr), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    check("rst_wr", 32'(ram_wr), 32'd0);
    check("rst_cs", 32'(ram_cs), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full write+verify from address 0.
    run(2'b11, 10'd0, 11'd17, 8'd0, 85, 0);
    check("full_mem0", 32'(mem[0]), 32'd0);
    check("full_mem9", 32'(mem[9]), 32'd18);
    check("full_mem16", 32'(mem[16]), 32'd32);
    check("full_pass", 32'(pass), 32'd1);
    check("full_err", 32'(err_count), 32'd0);

    // Window wrapping past the top address.
    run(2'b11, 10'd1020, 11'd8, 8'd5, 40, 0);
    check("wrap_mem1020", 32'(mem[1020]), 32'd5);
    check("wrap_mem1023", 32'(mem[1023]), 32'd11);
    check("wrap_mem0", 32'(mem[0]), 32'd13);
    check("wrap_mem3", 32'(mem[3]), 32'd19);
    check("wrap_pass", 32'(pass), 32'd1);

    // Write-only, corrupt one word, then verify-only.
    run(2'b01, 10'd100, 11'd4, 8'd0, 12, 0);
    check("wo_pass", 32'(pass), 32'd1);
    @(negedge clk);
    inj_addr = 10'd102; inj_data = 8'hFF; inj_en = 1'b1;
    model_mem[10'd102] = 8'hFF;
    #1 inj_en = 1'b0;
    run(2'b10, 10'd100, 11'd4, 8'd0, 8, 0);
    check("fault_err", 32'(err_count), 32'd1);
    check("fault_first", 32'(first_err_addr), 32'd102);
    check("fault_pass", 32'(pass), 32'd0);

    // Degenerate runs: no RAM activity, immediate done.
    run(2'b11, 10'd50, 11'd0, 8'd7, 0, 0);
    check("n0_pass", 32'(pass), 32'd1);
    run(2'b00, 10'd50, 11'd5, 8'd7, 0, 0);
    check("m00_pass", 32'(pass), 32'd1);

    // Second start mid-run must be ignored.
    run(2'b11, 10'd300, 11'd10, 8'd1, 50, 20);
    check("busy_start_pass", 32'(pass), 32'd1);
    check("busy_start_err", 32'(err_count), 32'd0);

    // Asynchronous reset during the write strobe of word 3.
    @(negedge clk);
    mode = 2'b11; base_addr = 10'd200; count = 11'd10; seed = 8'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_wr", 32'(ram_wr), 32'd1);
    check("mid_addr", 32'(ram_addr), 32'd203);
    check("mid_wdata", 32'(ram_wdata), 32'd9);
    for (int k = 0; k < 4; k++) model_mem[10'd200 + 10'(k)] = 8'(2 * k + 3);
    #1 rst = 1'b1;
    #1;
    check("arst_wr", 32'(ram_wr), 32'd0);
    check("arst_cs", 32'(ram_cs), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle", 32'(busy), 32'd0);
    run(2'b11, 10'd200, 11'd10, 8'd3, 50, 0);
    check("post_rst_pass", 32'(pass), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
